// File: rtl/axi4lite_apb_bridge_mc.sv
// AXI4-Lite slave to multi-slave APB4 master bridge, one APB transfer in flight.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module axi4lite_apb_bridge_mc #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SLV_ADDR_BITS  = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_SLAVES-1:0]          psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic [2:0]                     pprot,
  output logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH/8-1:0]        pstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]          pready,
  input  logic [NUM_SLAVES-1:0]          pslverr
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int SEL_W   = $clog2(NUM_SLAVES);
  localparam int IDX_W   = (SEL_W > 0) ? SEL_W : 1;
  localparam int DEC_LSB = SLV_ADDR_BITS + SEL_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_WRESP,
    S_RRESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_init;
  logic                  r_aw_full;
  logic                  r_w_full;
  logic                  r_ar_full;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [2:0]            r_aw_prot;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [STRB_W-1:0]     r_w_strb;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic [2:0]            r_ar_prot;
  logic                  r_rr_rd;
  logic                  r_is_wr;

  logic [NUM_SLAVES-1:0] r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [2:0]            r_pprot;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [STRB_W-1:0]     r_pstrb;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_bresp;
  logic [1:0]            r_rresp;

  logic                  w_wr_elig;
  logic                  w_rd_elig;
  logic                  w_grant_wr;
  logic                  w_grant_rd;
  logic                  w_grant;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic                  w_dec_err;
  logic [IDX_W-1:0]      w_req_idx;
  logic [NUM_SLAVES-1:0] w_req_oh;
  logic                  w_pready;
  logic                  w_pslverr;
  logic [DATA_WIDTH-1:0] w_prdata;
  logic                  w_bdone;
  logic                  w_rdone;
  logic                  w_tmo;

  assign awready = r_init & ~r_aw_full;
  assign wready  = r_init & ~r_w_full;
  assign arready = r_init & ~r_ar_full;
  assign bvalid  = (r_state == S_WRESP);
  assign rvalid  = (r_state == S_RRESP);
  assign bresp   = r_bresp;
  assign rresp   = r_rresp;
  assign rdata   = r_rdata;
  assign psel    = r_psel;
  assign penable = r_penable;
  assign pwrite  = r_pwrite;
  assign paddr   = r_paddr;
  assign pprot   = r_pprot;
  assign pwdata  = r_pwdata;
  assign pstrb   = r_pstrb;

  assign w_bdone = bvalid & bready;
  assign w_rdone = rvalid & rready;

  // Round-robin only matters when both directions contend.
  assign w_wr_elig  = r_aw_full & r_w_full;
  assign w_rd_elig  = r_ar_full;
  assign w_grant_wr = w_wr_elig & (~w_rd_elig | ~r_rr_rd);
  assign w_grant_rd = w_rd_elig & ~w_grant_wr;
  assign w_grant    = w_grant_wr | w_grant_rd;

  assign w_req_addr = w_grant_wr ? r_aw_addr : r_ar_addr;
  assign w_dec_err  = (w_req_addr >> DEC_LSB) != '0;
  assign w_req_idx  = (SEL_W == 0) ? '0 :
                      IDX_W'(w_req_addr >> SLV_ADDR_BITS);
  assign w_req_oh   = NUM_SLAVES'(1) << w_req_idx;

  assign w_pready  = |(pready & r_psel);
  assign w_pslverr = |(pslverr & r_psel);

  always_comb begin
    w_prdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_psel[i])
        w_prdata = w_prdata | prdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tcnt;

  assign w_tmo = ~w_pready &
                 (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_tcnt <= '0;
    else if (r_state != S_ACCESS)
      r_tcnt <= '0;
    else
      r_tcnt <= r_tcnt + 1'b1;
  end
`else
  logic w_unused_tmo_cfg;

  assign w_unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          if (w_dec_err)
            w_next = w_grant_wr ? S_WRESP : S_RRESP;
          else
            w_next = S_SETUP;
        end
      end
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: begin
        if (w_pready || w_tmo)
          w_next = r_is_wr ? S_WRESP : S_RRESP;
      end
      S_WRESP:  if (bready) w_next = S_IDLE;
      S_RRESP:  if (rready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init    <= 1'b0;
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_ar_full <= 1'b0;
      r_aw_addr <= '0;
      r_aw_prot <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_ar_addr <= '0;
      r_ar_prot <= '0;
    end else begin
      r_init <= 1'b1;
      if (awvalid && awready) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= awaddr;
        r_aw_prot <= awprot;
      end else if (w_bdone) begin
        r_aw_full <= 1'b0;
      end
      if (wvalid && wready) begin
        r_w_full <= 1'b1;
        r_w_data <= wdata;
        r_w_strb <= wstrb;
      end else if (w_bdone) begin
        r_w_full <= 1'b0;
      end
      if (arvalid && arready) begin
        r_ar_full <= 1'b1;
        r_ar_addr <= araddr;
        r_ar_prot <= arprot;
      end else if (w_rdone) begin
        r_ar_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_rd   <= 1'b0;
      r_is_wr   <= 1'b0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pprot   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_rdata   <= '0;
      r_bresp   <= '0;
      r_rresp   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_is_wr <= w_grant_wr;
            if (w_wr_elig && w_rd_elig)
              r_rr_rd <= ~r_rr_rd;
            if (w_dec_err) begin
              if (w_grant_wr) begin
                r_bresp <= 2'b11;
              end else begin
                r_rresp <= 2'b11;
                r_rdata <= '0;
              end
            end else begin
              r_psel    <= w_req_oh;
              r_penable <= 1'b0;
              r_paddr   <= w_req_addr;
              r_pwrite  <= w_grant_wr;
              if (w_grant_wr) begin
                r_pprot  <= r_aw_prot;
                r_pwdata <= r_w_data;
                r_pstrb  <= r_w_strb;
              end else begin
                r_pprot  <= r_ar_prot;
                r_pstrb  <= '0;
              end
            end
          end
        end
        S_SETUP: r_penable <= 1'b1;
        S_ACCESS: begin
          if (w_pready) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            if (r_is_wr) begin
              r_bresp <= w_pslverr ? 2'b10 : 2'b00;
            end else begin
              r_rresp <= w_pslverr ? 2'b10 : 2'b00;
              r_rdata <= w_prdata;
            end
          end else if (w_tmo) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            if (r_is_wr) begin
              r_bresp <= 2'b10;
            end else begin
              r_rresp <= 2'b10;
              r_rdata <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_apb_bridge_mc.sv
// Directed bench for axi4lite_apb_bridge_mc: vector table plus
// hand sequences for buffering, arbitration, reset and timeout.
module tb_axi4lite_apb_bridge_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [127:0] prdata;
  logic [3:0]  pready;
  logic [3:0]  pslverr;

  axi4lite_apb_bridge_mc #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_SLAVES(4),
    .SLV_ADDR_BITS(12), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid),
    .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
    .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .rready(rready),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pprot(pprot), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wcnt = 0;
  int          setup_cnt = 0;
  int          apb_cnt = 0;
  int          sl_wait = 0;
  bit          sl_err = 0;
  bit          stuck = 0;
  logic [31:0] sl_prd = '0;
  logic [3:0]  mon_sel = '0;
  logic [31:0] mon_addr = '0;
  logic [31:0] mon_wdata = '0;
  logic [3:0]  mon_strb = '0;
  logic [2:0]  mon_prot = '0;
  logic        mon_wr = 1'b0;
  logic [7:0]  hist = '0;

  // Slave model: only the selected slave answers.
  always_comb begin
    pready  = '0;
    pslverr = '0;
    prdata  = '0;
    for (int i = 0; i < 4; i++) begin
      pready[i]  = psel[i] & penable & ~stuck & (wcnt >= sl_wait);
      pslverr[i] = psel[i] & sl_err;
      prdata[i*32 +: 32] = psel[i] ? sl_prd : ~sl_prd;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (penable) wcnt <= wcnt + 1;
    else         wcnt <= 0;
    if ((psel != 0) && !penable) setup_cnt <= setup_cnt + 1;
    if (penable && ((psel & pready) != 0)) begin
      apb_cnt   <= apb_cnt + 1;
      mon_sel   <= psel;
      mon_addr  <= paddr;
      mon_wdata <= pwdata;
      mon_strb  <= pstrb;
      mon_prot  <= pprot;
      mon_wr    <= pwrite;
      hist      <= {hist[6:0], pwrite};
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input bit da, input bit dw, input bit dr,
                           input logic [31:0] aa,
                           input logic [31:0] wd,
                           input logic [3:0] st,
                           input logic [31:0] ra, output int hs);
    bit a, w, r;
    int n;
    awaddr = aa; awprot = 3'b001; awvalid = da;
    wdata = wd; wstrb = st; wvalid = dw;
    araddr = ra; arprot = 3'b100; arvalid = dr;
    n = 0;
    while ((awvalid || wvalid || arvalid) && n < 50) begin
      a = awvalid && awready;
      w = wvalid && wready;
      r = arvalid && arready;
      @(posedge clk); #1;
      if (a) awvalid = 1'b0;
      if (w) wvalid = 1'b0;
      if (r) arvalid = 1'b0;
      n++;
    end
    hs = cyc;
    chk("handshake_pending", {awvalid, wvalid, arvalid}, 0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
  endtask

  task automatic wait_resp(input bit is_wr, output int seen,
                           output logic [1:0] resp,
                           output logic [31:0] data);
    int n;
    n = 0;
    while (!(is_wr ? bvalid : rvalid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    seen = cyc;
    chk("resp_valid", is_wr ? bvalid : rvalid, 1);
    resp = is_wr ? bresp : rresp;
    data = rdata;
    if (is_wr ? bready : rready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    int          waits;
    bit          err;
    logic [31:0] prd;
    logic [3:0]  e_sel;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    int          e_lat;
  } vec_t;

  vec_t vt[7];

  initial begin
    int hs, seen, c0, s0, n;
    logic [1:0]  resp;
    logic [31:0] data;
    bit          seen_rv;

    vt[0] = '{1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0,
              32'h0, 4'b0010, 2'b00, 32'h0, 3};
    vt[1] = '{0, 32'h0000_2004, 32'h0, 4'h0, 3, 0,
              32'h1234_5678, 4'b0100, 2'b00, 32'h1234_5678, 6};
    vt[2] = '{0, 32'h0001_0000, 32'h0, 4'h0, 0, 0,
              32'h5555_AAAA, 4'b0000, 2'b11, 32'h0, 1};
    vt[3] = '{1, 32'h0000_3FFC, 32'hA5A5_0001, 4'h3, 1, 1,
              32'h0, 4'b1000, 2'b10, 32'h0, 4};
    vt[4] = '{0, 32'h0000_0008, 32'h0, 4'h0, 0, 1,
              32'hCAFE_F00D, 4'b0001, 2'b10, 32'hCAFE_F00D, 3};
    vt[5] = '{1, 32'h0000_4000, 32'h0123_4567, 4'hF, 0, 0,
              32'h0, 4'b0000, 2'b11, 32'h0, 1};
    vt[6] = '{0, 32'h0000_3000, 32'h0, 4'h0, 2, 0,
              32'h0BAD_F00D, 4'b1000, 2'b00, 32'h0BAD_F00D, 5};

    rst = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_pprot", pprot, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {awready, wready, arready}, 3'b111);

    for (int v = 0; v < 7; v++) begin
      sl_wait = vt[v].waits;
      sl_err  = vt[v].err;
      sl_prd  = vt[v].prd;
      c0 = apb_cnt;
      drive_req(vt[v].wr, vt[v].wr, !vt[v].wr, vt[v].addr,
                vt[v].wd, vt[v].strb, vt[v].addr, hs);
      wait_resp(vt[v].wr, seen, resp, data);
      chk($sformatf("v%0d_latency", v), seen - hs, vt[v].e_lat);
      chk($sformatf("v%0d_resp", v), resp, vt[v].e_resp);
      if (!vt[v].wr)
        chk($sformatf("v%0d_rdata", v), data, vt[v].e_rdata);
      chk($sformatf("v%0d_apb_count", v), apb_cnt - c0,
          (vt[v].e_sel != 0) ? 1 : 0);
      if (vt[v].e_sel != 0) begin
        chk($sformatf("v%0d_psel", v), mon_sel, vt[v].e_sel);
        chk($sformatf("v%0d_paddr", v), mon_addr, vt[v].addr);
        chk($sformatf("v%0d_pwrite", v), mon_wr, vt[v].wr);
        chk($sformatf("v%0d_pprot", v), mon_prot,
            vt[v].wr ? 3'b001 : 3'b100);
        chk($sformatf("v%0d_pstrb", v), mon_strb,
            vt[v].wr ? vt[v].strb : 4'h0);
        if (vt[v].wr)
          chk($sformatf("v%0d_pwdata", v), mon_wdata, vt[v].wd);
      end
    end

    // W arrives well before AW; response held while bready is low.
    sl_wait = 0; sl_err = 1;
    s0 = setup_cnt;
    drive_req(0, 1, 0, 32'h0, 32'h600D_F00D, 4'hC, 32'h0, hs);
    repeat (5) begin @(posedge clk); #1; end
    chk("wfirst_no_setup", setup_cnt - s0, 0);
    chk("wfirst_psel_idle", psel, 0);
    chk("wfirst_wready_low", wready, 0);
    bready = 1'b0;
    drive_req(1, 0, 0, 32'h0000_1010, 32'h0, 4'h0, 32'h0, hs);
    wait_resp(1, seen, resp, data);
    chk("wfirst_latency", seen - hs, 3);
    chk("wfirst_bresp", resp, 2'b10);
    chk("wfirst_pwdata", mon_wdata, 32'h600D_F00D);
    chk("wfirst_pstrb", mon_strb, 4'hC);
    chk("wfirst_paddr", mon_addr, 32'h0000_1010);
    chk("wfirst_psel", mon_sel, 4'b0010);
    repeat (3) begin @(posedge clk); #1; end
    chk("bhold_valid", bvalid, 1);
    chk("bhold_resp", bresp, 2'b10);
    bready = 1'b1;
    @(posedge clk); #1;
    chk("bhold_done", bvalid, 0);
    sl_err = 0;

    // Contention: write wins after reset, read wins the next round.
    apply_reset();
    for (int round = 0; round < 2; round++) begin
      c0 = apb_cnt;
      drive_req(1, 1, 1, 32'h0000_1000, 32'h1111_2222, 4'hF,
                32'h0000_2000, hs);
      n = 0;
      while ((apb_cnt - c0) < 2 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      repeat (3) begin @(posedge clk); #1; end
      chk($sformatf("arb%0d_count", round), apb_cnt - c0, 2);
      chk($sformatf("arb%0d_order", round), hist[1:0],
          (round == 0) ? 2'b10 : 2'b01);
      chk($sformatf("arb%0d_idle", round), {bvalid, rvalid}, 0);
    end

`ifdef APB_TIMEOUT_EN
    stuck = 1;
    drive_req(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0000_2000, hs);
    wait_resp(0, seen, resp, data);
    chk("tmo_latency", seen - hs, 10);
    chk("tmo_rresp", resp, 2'b10);
    chk("tmo_rdata", data, 0);
    chk("tmo_psel", psel, 0);
    stuck = 0;
`endif

    // Reset while a read waits in ACCESS.
    stuck = 1;
    drive_req(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0000_1000, hs);
    n = 0;
    while (!penable && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rstmid_access", {penable, psel}, 5'b10010);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rstmid_psel", psel, 0);
    chk("rstmid_penable", penable, 0);
    chk("rstmid_rvalid", rvalid, 0);
    @(posedge clk); #1;
    stuck = 0;
    s0 = setup_cnt;
    rst = 1'b1;
    seen_rv = 0;
    repeat (10) begin
      @(posedge clk); #1;
      seen_rv |= rvalid;
    end
    chk("rstmid_no_rvalid", seen_rv, 0);
    chk("rstmid_no_apb", setup_cnt - s0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
